// File: rtl/delay_sched.sv
// Frame scheduler for the shared DELAY datapath: for each codec channel it
// reads state from RAM, loads and steps DELAY, then writes the result back.
module delay_sched #(
    parameter int NCH  = 32,
    parameter int CH_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            frame_sync,
    output logic            mem_rd_req,
    input  logic            mem_rd_ack,
    output logic            mem_wr_req,
    input  logic            mem_wr_ack,
    output logic [CH_W-1:0] ch_addr,
    output logic            dly_load,
    output logic            dly_en,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    input  logic            clr_overrun,
    input  logic            scan_in0,
    input  logic            scan_in1,
    input  logic            scan_in2,
    input  logic            scan_in3,
    input  logic            scan_in4,
    input  logic            scan_enable,
    input  logic            test_mode,
    output logic            scan_out0,
    output logic            scan_out1,
    output logic            scan_out2,
    output logic            scan_out3,
    output logic            scan_out4
);

    typedef enum logic [2:0] {IDLE, RD, LOAD, UPD, WR, DONE} state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CH_W-1:0] r_ch;
    logic            r_overrun;
    logic            w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_sync && enable) w_next = RD;
            RD:      if (mem_rd_ack) w_next = LOAD;
            LOAD:    w_next = UPD;
            UPD:     w_next = WR;
            WR:      if (mem_wr_ack) w_next = (r_ch == LAST_CH) ? DONE : RD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Channel index wraps to 0 as the last write completes, so DONE/IDLE sit at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch <= '0;
        end else if (r_state == IDLE && w_next == RD) begin
            r_ch <= '0;
        end else if (r_state == WR && mem_wr_ack) begin
            r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
        end
    end

    // A frame strobe that arrives while busy wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              r_overrun <= 1'b0;
        else if (frame_sync && r_state != IDLE)  r_overrun <= 1'b1;
        else if (clr_overrun)                    r_overrun <= 1'b0;
    end

    assign mem_rd_req = (r_state == RD);
    assign mem_wr_req = (r_state == WR);
    assign dly_load   = (r_state == LOAD);
    assign dly_en     = (r_state == UPD);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign ch_addr    = r_ch;
    assign overrun    = r_overrun;

    // Scan chains are inserted at synthesis; RTL holds the outputs low.
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
    assign w_unused  = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboard bench for delay_sched (NCH=4): stimulus queues expected DELAY
// strobes and done pulses with their cycle numbers; a negedge monitor pops them.
module tb_delay_sched;

    localparam int NCH  = 4;
    localparam int CH_W = 2;
    localparam int K_LOAD = 0, K_EN = 1, K_DONE = 2;

    typedef struct { int kind; int ch; int cyc; } ev_t;

    logic clk = 0, reset = 0, enable = 0, frame_sync = 0, clr_overrun = 0;
    logic mem_rd_ack = 1, mem_wr_ack = 1;
    logic scan_in0 = 0, scan_in1 = 0, scan_in2 = 0, scan_in3 = 0, scan_in4 = 0;
    logic scan_enable = 0, test_mode = 0;
    logic mem_rd_req, mem_wr_req, dly_load, dly_en, busy, done, overrun;
    logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic [CH_W-1:0] ch_addr;

    delay_sched #(.NCH(NCH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
        .ch_addr(ch_addr), .dly_load(dly_load), .dly_en(dly_en),
        .busy(busy), .done(done), .overrun(overrun), .clr_overrun(clr_overrun),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   passed = 0, total = 0;
    ev_t  expq[$];
    int   ch_cyc[NCH];
    int   rd_cyc[NCH];
    int   last_done = -1;
    int   stall_ch = -1, stall_left = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic got_ev(input int k, input int ch);
        ev_t e;
        if (expq.size() == 0) begin
            check($sformatf("unexpected_event_kind%0d", k), 1, 0);
        end else begin
            e = expq.pop_front();
            check("event_kind", k, e.kind);
            if (e.ch >= 0) check("event_ch", ch, e.ch);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: invariants every cycle, then scoreboard pops on each strobe.
    always @(negedge clk) begin
        if (reset) begin
            check("rd_wr_exclusive", mem_rd_req & mem_wr_req, 0);
            check("load_en_exclusive", dly_load & dly_en, 0);
            check("ch_addr_range", (int'(ch_addr) <= NCH - 1), 1);
            if (busy && !done) ch_cyc[ch_addr]++;
            if (mem_rd_req) rd_cyc[ch_addr]++;
            if (dly_load) got_ev(K_LOAD, int'(ch_addr));
            if (dly_en)   got_ev(K_EN, int'(ch_addr));
            if (done) begin
                got_ev(K_DONE, -1);
                last_done = cyc;
            end
        end
    end

    // RAM model: read ack withheld for stall_left cycles on channel stall_ch.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd_req && int'(ch_addr) == stall_ch && stall_left > 0) begin
                mem_rd_ack = 0;
                stall_left--;
            end else begin
                mem_rd_ack = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Expected events for a frame whose frame_sync is sampled at the end of cycle t0.
    task automatic push_frame(input int t0, input int last_ch, input int st_ch,
                              input int st_n, input bit with_done);
        int t = t0 + 1;
        for (int c = 0; c <= last_ch; c++) begin
            if (c == st_ch) t += st_n;
            expq.push_back('{K_LOAD, c, t + 1});
            expq.push_back('{K_EN,   c, t + 2});
            t += 4;
        end
        if (with_done) expq.push_back('{K_DONE, -1, t});
    endtask

    task automatic pulse_sync();
        frame_sync = 1;
        step();
        frame_sync = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_rdreq"}, mem_rd_req, 0);
        check({name, "_wrreq"}, mem_wr_req, 0);
        check({name, "_load"}, dly_load, 0);
        check({name, "_en"}, dly_en, 0);
        check({name, "_ch"}, ch_addr, 0);
        check({name, "_overrun"}, overrun, 0);
        check({name, "_scan"}, {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int snap[NCH];

        #2;
        check_all_zero("reset");
        step();
        step();
        reset = 1;
        enable = 1;
        step();

        // Nominal frame: 4 cycles per channel, done at +17, idle at +18.
        foreach (snap[i]) snap[i] = ch_cyc[i];
        t0 = cyc;
        push_frame(t0, NCH - 1, -1, 0, 1);
        pulse_sync();
        check("busy_after_sync", busy, 1);
        wait_idle("nominal_idle");
        check("nominal_done_cycle", last_done - t0, 17);
        check("nominal_idle_cycle", cyc - t0, 18);
        for (int i = 0; i < NCH; i++) check($sformatf("nominal_ch%0d_cycles", i), ch_cyc[i] - snap[i], 4);
        check("nominal_ch_after", ch_addr, 0);
        check("nominal_queue_empty", expq.size(), 0);
        step();

        // Read ack held off 3 cycles on channel 2.
        foreach (snap[i]) snap[i] = rd_cyc[i];
        stall_ch = 2;
        stall_left = 3;
        t0 = cyc;
        push_frame(t0, NCH - 1, 2, 3, 1);
        pulse_sync();
        wait_idle("stall_idle");
        check("stall_rd_cycles_ch2", rd_cyc[2] - snap[2], 4);
        check("stall_rd_cycles_ch1", rd_cyc[1] - snap[1], 1);
        check("stall_done_cycle", last_done - t0, 20);
        check("stall_queue_empty", expq.size(), 0);
        stall_ch = -1;
        step();

        // Frame strobe during a frame: overrun set, frame undisturbed.
        t0 = cyc;
        push_frame(t0, NCH - 1, -1, 0, 1);
        pulse_sync();
        step_to(t0 + 6);
        check("overrun_before", overrun, 0);
        pulse_sync();
        check("overrun_set", overrun, 1);
        frame_sync = 1;
        clr_overrun = 1;
        step();
        frame_sync = 0;
        clr_overrun = 0;
        check("overrun_set_beats_clr", overrun, 1);
        wait_idle("overrun_idle");
        check("overrun_done_cycle", last_done - t0, 17);
        step_to(t0 + 30);
        check("overrun_sticky", overrun, 1);
        clr_overrun = 1;
        step();
        clr_overrun = 0;
        check("overrun_cleared", overrun, 0);
        check("overrun_queue_empty", expq.size(), 0);

        // Disabled: strobe ignored.
        enable = 0;
        pulse_sync();
        for (int i = 0; i < 4; i++) begin
            check("disabled_busy", busy, 0);
            check("disabled_rdreq", mem_rd_req, 0);
            step();
        end
        // Enable dropped mid-frame: frame still completes.
        enable = 1;
        t0 = cyc;
        push_frame(t0, NCH - 1, -1, 0, 1);
        pulse_sync();
        step_to(t0 + 5);
        enable = 0;
        wait_idle("enable_drop_idle");
        check("enable_drop_done_cycle", last_done - t0, 17);
        pulse_sync();
        check("enable_drop_next_ignored", busy, 0);
        enable = 1;
        step();

        // Reset while channel 2 is in RD: abandon frame, no done.
        t0 = cyc;
        push_frame(t0, 1, -1, 0, 0);
        pulse_sync();
        step_to(t0 + 3);
        pulse_sync();
        step_to(t0 + 9);
        check("prereset_rdreq", mem_rd_req, 1);
        check("prereset_ch", ch_addr, 2);
        check("prereset_overrun", overrun, 1);
        reset = 0;
        #1;
        check_all_zero("midreset");
        check("midreset_queue_empty", expq.size(), 0);
        step();
        step();
        reset = 1;
        step();
        check("postreset_idle", busy, 0);
        t0 = cyc;
        push_frame(t0, NCH - 1, -1, 0, 1);
        pulse_sync();
        check("restart_ch", ch_addr, 0);
        wait_idle("restart_idle");
        check("restart_done_cycle", last_done - t0, 17);
        check("final_queue_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
